// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_e;

    localparam int SEG_DP_BIT = 7;
    localparam int BCD_W      = 4;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blanking mask computed over the frame snapshot.
module seg_lz_mask
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [BCD_W*NUM_DIGITS-1:0] snap,
    input  logic                        lz_suppress,
    output logic [NUM_DIGITS-1:0]       suppressed
);

    logic upper_zero;

    // Digit 0 always shows, so a zero value still displays "0".
    always_comb begin
        suppressed = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero    = upper_zero & (snap[i*BCD_W +: BCD_W] == '0);
            suppressed[i] = lz_suppress & upper_zero;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-frame snapshot,
// blanking gaps and leading-zero suppression around a shared decoder.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        load,
    output logic                        load_ack,
    input  logic                        enable,
    input  logic                        lz_suppress,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    output logic [7:0]                  dec_bcd,
    input  logic [7:0]                  dec_seg,
    output logic [7:0]                  seg_out,
    output logic [NUM_DIGITS-1:0]       dig_sel,
    output logic                        frame_start
);

    localparam int T_MAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                           DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW = $clog2(T_MAX + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] T_DWELL = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST    = IW'(NUM_DIGITS - 1);

    scan_state_e                 state;
    logic [TW-1:0]               timer;
    logic [IW-1:0]               idx;
    logic [IW-1:0]               idx_nxt;
    logic [IW-1:0]               blank_idx;
    logic [BCD_W*NUM_DIGITS-1:0] snap;
    logic [NUM_DIGITS-1:0]       dp_snap;
    logic [NUM_DIGITS-1:0]       suppressed;
    logic                        load_pending;
    logic                        go_blank;
    logic                        frame_now;
    logic                        snap_now;
    logic                        expired;
    logic [BCD_W-1:0]            nib;
    logic [7:0]                  seg_nxt;

    seg_lz_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lz (
        .snap       (snap),
        .lz_suppress(lz_suppress),
        .suppressed (suppressed)
    );

    assign expired = (timer == '0);
    assign idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;

    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) nib = snap[i*BCD_W +: BCD_W];
        end
    end

    assign dec_bcd = {{(8 - BCD_W){1'b0}}, nib};

    always_comb begin
        seg_nxt             = dec_seg & 8'h7F;
        seg_nxt[SEG_DP_BIT] = dp_snap[idx];
        if (suppressed[idx]) seg_nxt = '0;
    end

    // Frame boundary is any entry into BLANK at digit 0.
    always_comb begin
        go_blank  = 1'b0;
        blank_idx = idx;
        unique case (state)
            IDLE:  go_blank = enable;
            BLANK: go_blank = 1'b0;
            SHOW: begin
                go_blank  = expired & enable;
                blank_idx = idx_nxt;
            end
            default: go_blank = 1'b0;
        endcase
    end

    assign frame_now = go_blank & (blank_idx == '0);
    assign snap_now  = frame_now & load_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            idx          <= '0;
            snap         <= '0;
            dp_snap      <= '0;
            load_pending <= 1'b0;
            load_ack     <= 1'b0;
            frame_start  <= 1'b0;
            seg_out      <= '0;
            dig_sel      <= '0;
        end else begin
            frame_start  <= frame_now;
            load_ack     <= snap_now;
            load_pending <= snap_now ? 1'b0 : (load_pending | load);
            if (snap_now) begin
                snap    <= digits_in;
                dp_snap <= dp_mask;
            end
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= BLANK;
                        timer <= T_BLANK;
                    end
                end
                BLANK: begin
                    if (expired) begin
                        state   <= SHOW;
                        timer   <= T_DWELL;
                        seg_out <= seg_nxt;
                        dig_sel <= NUM_DIGITS'(onehot(3'(idx)));
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SHOW: begin
                    if (expired) begin
                        idx     <= idx_nxt;
                        seg_out <= '0;
                        dig_sel <= '0;
                        state   <= enable ? BLANK : IDLE;
                        timer   <= enable ? T_BLANK : '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a frame-level display model.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic        load_ack;
    logic        enable;
    logic        lz_suppress;
    logic [3:0]  dp_mask;
    logic [7:0]  dec_bcd;
    logic [7:0]  dec_seg;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: seg7 = 8'h3F;
            4'd1: seg7 = 8'h06;
            4'd2: seg7 = 8'h5B;
            4'd3: seg7 = 8'h4F;
            4'd4: seg7 = 8'h66;
            4'd5: seg7 = 8'h6D;
            4'd6: seg7 = 8'h7D;
            4'd7: seg7 = 8'h07;
            4'd8: seg7 = 8'h7F;
            4'd9: seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // External shared decoder
    assign dec_seg = (dec_bcd[7:4] == 4'h0) ? seg7(dec_bcd[3:0]) : 8'h00;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .load_ack   (load_ack),
        .enable     (enable),
        .lz_suppress(lz_suppress),
        .dp_mask    (dp_mask),
        .dec_bcd    (dec_bcd),
        .dec_seg    (dec_seg),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    function automatic logic [7:0] model_seg(input logic [15:0] s,
                                             input logic [3:0] dp,
                                             input logic lz, input int k);
        logic [15:0] up;
        logic [7:0]  seg;
        up     = s >> (4 * k);
        seg    = seg7(up[3:0]);
        seg[7] = dp[k];
        if (lz && k > 0 && up == 16'h0) seg = 8'h00;
        return seg;
    endfunction

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        int nz;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 3) != 0) v[4*i +: 4] = 4'($urandom_range(0, 9));
        nz = $urandom_range(0, 4);
        for (int i = 0; i < nz; i++) v[15 - 4*i -: 4] = 4'h0;
        return v;
    endfunction

    // Waits for a frame, checks every cycle of it, optionally loads mid-frame.
    task automatic run_frame(input logic [15:0] s, input logic [3:0] dp,
                             input logic lz, input logic ack,
                             input int max_wait, input int load_at,
                             input logic [15:0] nd, input logic [3:0] ndp,
                             input logic noise, input string tag);
        bit got;
        int k, c;
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        logic [7:0] exp_bcd;
        logic [1:0] exp_fl;
        lz_suppress = lz;
        got = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s frame_start wait got none exp pulse", tag);
            return;
        end
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            k = t / SLOT;
            c = t % SLOT;
            exp_dig = (c < BL) ? 4'h0 : 4'(1 << k);
            exp_seg = (c < BL) ? 8'h00 : model_seg(s, dp, lz, k);
            checks++;
            if ({dig_sel, seg_out} !== {exp_dig, exp_seg}) begin
                errors++;
                $display("FAIL %s t=%0d dig/seg got %b/%h exp %b/%h",
                         tag, t, dig_sel, seg_out, exp_dig, exp_seg);
            end
            exp_fl = {t == 0, (t == 0) && ack};
            checks++;
            if ({frame_start, load_ack} !== exp_fl) begin
                errors++;
                $display("FAIL %s t=%0d fs/ack got %b%b exp %b",
                         tag, t, frame_start, load_ack, exp_fl);
            end
            if (c < BL) begin
                exp_bcd = {4'h0, 4'(s >> (4 * k))};
                checks++;
                if (dec_bcd !== exp_bcd) begin
                    errors++;
                    $display("FAIL %s t=%0d dec_bcd got %h exp %h",
                             tag, t, dec_bcd, exp_bcd);
                end
            end
            if (t == load_at) begin
                digits_in = nd;
                dp_mask   = ndp;
                load      = 1'b1;
            end else begin
                load = 1'b0;
                if (noise && (load_at < 0 || t < load_at)) begin
                    digits_in = 16'($urandom);
                    dp_mask   = 4'($urandom);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        load = 1'b1;
        digits_in = 16'h9876;
        dp_mask = 4'hF;
        lz_suppress = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg_out, dig_sel, load_ack, frame_start, dec_bcd} !== 22'h0) begin
            errors++;
            $display("FAIL reset outs got %h/%b/%b/%b/%h exp all 0",
                     seg_out, dig_sel, load_ack, frame_start, dec_bcd);
        end
        enable = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg_out, dig_sel, frame_start} !== 13'h0) begin
            errors++;
            $display("FAIL idle outs got %h/%b/%b exp 0",
                     seg_out, dig_sel, frame_start);
        end
    endtask

    task automatic test_scan();
        digits_in = 16'h1234;
        dp_mask = 4'h0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        enable = 1'b1;
        run_frame(16'h1234, 4'h0, 1'b0, 1'b1, 1, -1, 16'h0, 4'h0, 1'b0, "scan1");
        run_frame(16'h1234, 4'h0, 1'b0, 1'b0, 2*FRAME, -1, 16'h0, 4'h0, 1'b0, "scan2");
    endtask

    task automatic test_lz_suppress();
        run_frame(16'h1234, 4'h0, 1'b0, 1'b0, 2*FRAME, 5, 16'h0007, 4'h0, 1'b0, "lz_old");
        run_frame(16'h0007, 4'h0, 1'b1, 1'b1, 2*FRAME, 7, 16'h0000, 4'h0, 1'b0, "lz_7");
        run_frame(16'h0000, 4'h0, 1'b1, 1'b1, 2*FRAME, -1, 16'h0, 4'h0, 1'b0, "lz_0");
    endtask

    task automatic test_dp();
        run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 2*FRAME, 3, 16'h00AB, 4'b0100, 1'b0, "dp_old");
        run_frame(16'h00AB, 4'b0100, 1'b0, 1'b1, 2*FRAME, -1, 16'h0, 4'h0, 1'b0, "dp_new");
    endtask

    task automatic test_mid_frame_load();
        run_frame(16'h00AB, 4'b0100, 1'b0, 1'b0, 2*FRAME, 10, 16'h5678, 4'b1001, 1'b1, "mid_old");
        run_frame(16'h5678, 4'b1001, 1'b0, 1'b1, 2*FRAME, -1, 16'h0, 4'h0, 1'b1, "mid_new");
    endtask

    task automatic test_enable_drop(input logic [15:0] s, input logic [3:0] dp);
        bit got;
        int k, c;
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        lz_suppress = 1'b0;
        got = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL en frame_start wait got none exp pulse");
            return;
        end
        for (int t = 0; t < 2*SLOT; t++) begin
            if (t > 0) @(negedge clk);
            k = t / SLOT;
            c = t % SLOT;
            exp_dig = (c < BL) ? 4'h0 : 4'(1 << k);
            exp_seg = (c < BL) ? 8'h00 : model_seg(s, dp, 1'b0, k);
            checks++;
            if ({dig_sel, seg_out} !== {exp_dig, exp_seg}) begin
                errors++;
                $display("FAIL en_pre t=%0d dig/seg got %b/%h exp %b/%h",
                         t, dig_sel, seg_out, exp_dig, exp_seg);
            end
            if (t == SLOT + BL + 1) enable = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({dig_sel, seg_out, frame_start} !== 13'h0) begin
                errors++;
                $display("FAIL en_idle i=%0d dig/seg/fs got %b/%h/%b exp 0",
                         i, dig_sel, seg_out, frame_start);
            end
        end
        enable = 1'b1;
        for (int t = 0; t < 2*SLOT; t++) begin
            @(negedge clk);
            k = 2 + t / SLOT;
            c = t % SLOT;
            exp_dig = (c < BL) ? 4'h0 : 4'(1 << k);
            exp_seg = (c < BL) ? 8'h00 : model_seg(s, dp, 1'b0, k);
            checks++;
            if ({dig_sel, seg_out} !== {exp_dig, exp_seg}) begin
                errors++;
                $display("FAIL en_post t=%0d dig/seg got %b/%h exp %b/%h",
                         t, dig_sel, seg_out, exp_dig, exp_seg);
            end
        end
        @(negedge clk);
        checks++;
        if ({frame_start, load_ack} !== 2'b10) begin
            errors++;
            $display("FAIL en_wrap fs/ack got %b%b exp 10", frame_start, load_ack);
        end
    endtask

    task automatic test_random(input logic [15:0] s0, input logic [3:0] dp0);
        logic [15:0] cur, nxt;
        logic [3:0]  cdp, ndp;
        logic        clz, nlz;
        cur = s0;
        cdp = dp0;
        clz = 1'b0;
        for (int r = 0; r < 6; r++) begin
            nxt = rand_digits();
            ndp = 4'($urandom);
            nlz = 1'($urandom);
            run_frame(cur, cdp, clz, 1'b0, 2*FRAME, $urandom_range(1, FRAME - 2),
                      nxt, ndp, 1'b1, "rnd_old");
            run_frame(nxt, ndp, nlz, 1'b1, 2*FRAME, -1, 16'h0, 4'h0, 1'b1, "rnd_new");
            cur = nxt;
            cdp = ndp;
            clz = nlz;
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        got = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            @(negedge clk);
            if (dig_sel != 4'h0) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_mid wait got no lit digit exp one");
            return;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({seg_out, dig_sel, frame_start, load_ack, dec_bcd} !== 22'h0) begin
            errors++;
            $display("FAIL rst_mid outs got %h/%b/%b/%b/%h exp all 0",
                     seg_out, dig_sel, frame_start, load_ack, dec_bcd);
        end
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 1, -1, 16'h0, 4'h0, 1'b0, "rst_resume");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_suppress();
        test_dp();
        test_mid_frame_load();
        test_enable_drop(16'h5678, 4'b1001);
        test_random(16'h5678, 4'b1001);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
